// File: rtl/byte_fetch_queue_pkg.sv
// Shared definitions for the instruction-byte fetch stage: reset vector
// addresses, default address width and the fetch state encoding.
package byte_fetch_queue_pkg;

  localparam int unsigned BFQ_ADDR_W = 16;

  localparam logic [15:0] RESET_VECTOR_LO = 16'hFFFC;
  localparam logic [15:0] RESET_VECTOR_HI = 16'hFFFD;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/byte_fetch_queue_fifo.sv
// Synchronous FIFO with flush and occupancy count; head is read combinationally.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    do_push  = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/byte_fetch_queue.sv
// Instruction-byte fetch stage: loads the 6502 reset vector, then streams
// sequential bytes into a small FIFO; redirects flush and drop stale responses.
module byte_fetch_queue
  import byte_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = BFQ_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [7:0]        mem_resp_data,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        lo_latch_q, lo_latch_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [7:0]        fifo_head;
  logic [CNT_W:0]    occupancy;
  logic              redirect, req_accept;
  logic              fifo_push, fifo_pop, fifo_flush;

  always_comb begin
    redirect      = (state_q == RUN) && redirect_valid;
    occupancy     = {1'b0, fifo_count} + {1'b0, inflight_q};
    mem_req_valid = 1'b0;
    mem_req_addr  = pc_q;
    case (state_q)
      VEC_LO: begin
        mem_req_valid = (inflight_q == '0);
        mem_req_addr  = ADDR_W'(RESET_VECTOR_LO);
      end
      VEC_HI: begin
        mem_req_valid = (inflight_q == '0);
        mem_req_addr  = ADDR_W'(RESET_VECTOR_HI);
      end
      RUN: begin
        mem_req_valid = (occupancy < (CNT_W + 1)'(DEPTH)) && !redirect_valid;
      end
      default: mem_req_valid = 1'b0;
    endcase
    if (rst) begin
      mem_req_valid = 1'b0;
    end
    req_accept = mem_req_valid && mem_req_ready;
    inflight_d = inflight_q + CNT_W'(req_accept) - CNT_W'(mem_resp_valid);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lo_latch_d = lo_latch_q;
    drop_cnt_d = drop_cnt_q;
    fifo_push  = 1'b0;
    case (state_q)
      VEC_LO: begin
        if (mem_resp_valid) begin
          lo_latch_d = mem_resp_data;
          state_d    = VEC_HI;
        end
      end
      VEC_HI: begin
        if (mem_resp_valid) begin
          pc_d    = ADDR_W'({mem_resp_data, lo_latch_q});
          state_d = RUN;
        end
      end
      RUN: begin
        // Everything still outstanding after this cycle belongs to the old stream
        if (redirect) begin
          pc_d       = redirect_pc;
          drop_cnt_d = inflight_d;
        end else begin
          if (req_accept) begin
            pc_d = pc_q + ADDR_W'(1);
          end
          if (mem_resp_valid) begin
            if (drop_cnt_q != '0) begin
              drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end else begin
              fifo_push = 1'b1;
            end
          end
        end
      end
      default: state_d = VEC_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= VEC_LO;
      pc_q       <= '0;
      lo_latch_q <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      lo_latch_q <= lo_latch_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign instr_valid = (fifo_count != '0) && !redirect_valid && !rst;
  assign fifo_pop    = instr_valid && instr_ready;
  assign fifo_flush  = redirect;
  assign instr       = fifo_head;
  assign fetch_pc    = pc_q;

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mem_resp_data),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_byte_fetch_queue.sv
// Self-checking bench: in-order memory model with programmable latency and a
// byte scoreboard filled on request acceptance, cleared on redirect/reset.
module tb_byte_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [15:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [7:0]  mem_resp_data;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] fetch_pc;

  always #5 clk = ~clk;

  byte_fetch_queue #(
    .DEPTH  (4),
    .ADDR_W (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .fetch_pc       (fetch_pc)
  );

  typedef struct {
    logic [15:0] addr;
    int unsigned due;
  } pend_t;

  typedef struct {
    logic [15:0] pc;
    int unsigned lat;
    bit          rnd;
    int unsigned nbytes;
    logic [7:0]  exp_first;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned lat = 2;
  bit          rnd_ready = 1'b0;
  logic [7:0]  vec_lo, vec_hi;

  pend_t       pend[$];
  logic [7:0]  exp_q[$];

  // Bench-side model of the fetch stage
  bit          model_run = 1'b0;
  int unsigned vec_cnt = 0;
  logic [15:0] model_pc = '0;
  int          model_inflight = 0;

  // Per-phase observations, cleared on reset and on redirect
  int unsigned pops_since = 0;
  int unsigned pops_total = 0;
  int unsigned acc_since = 0;
  logic [15:0] acc_log[4];
  bit          first_pop_seen = 1'b0;
  logic [7:0]  first_byte = '0;
  bit          first_addr_seen = 1'b0;
  logic [15:0] first_addr = '0;
  bit          first_run_seen = 1'b0;
  logic [15:0] first_run_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [7:0] mem_data(input logic [15:0] a);
    if (a == 16'hFFFC) return vec_lo;
    if (a == 16'hFFFD) return vec_hi;
    return a[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int unsigned n, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (pops_since >= n) begin
        done = 1'b1;
        break;
      end
    end
    #1;
    if (!done) check(name, pops_since, n);
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Memory model: strictly in-order responses, at least lat cycles after accept
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_req_ready  = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_data(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        mem_resp_valid = 1'b0;
      end
    end
  end

  // Monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      exp_q.delete();
      model_run       = 1'b0;
      vec_cnt         = 0;
      model_pc        = '0;
      model_inflight  = 0;
      pops_since      = 0;
      acc_since       = 0;
      first_pop_seen  = 1'b0;
      first_addr_seen = 1'b0;
      first_run_seen  = 1'b0;
    end else begin
      if (model_run) check("fetch_pc", fetch_pc, model_pc);
      if (model_run && redirect_valid) begin
        check("redirect_instr_valid", instr_valid, 1'b0);
        check("redirect_req_valid", mem_req_valid, 1'b0);
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", instr_valid, 1'b0);
        end else begin
          check("instr", instr, exp_q.pop_front());
        end
        if (!first_pop_seen) begin
          first_pop_seen = 1'b1;
          first_byte     = instr;
        end
        pops_since++;
        pops_total++;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (!model_run) begin
          check("vec_addr", mem_req_addr, (vec_cnt == 0) ? 16'hFFFC : 16'hFFFD);
        end else begin
          check("req_addr", mem_req_addr, model_pc);
          exp_q.push_back(mem_data(model_pc));
          model_pc = model_pc + 16'd1;
          if (!first_run_seen) begin
            first_run_seen = 1'b1;
            first_run_addr = mem_req_addr;
          end
        end
        pend.push_back('{mem_req_addr, cyc + lat});
        if (acc_since < 4) acc_log[acc_since] = mem_req_addr;
        if (!first_addr_seen) begin
          first_addr_seen = 1'b1;
          first_addr      = mem_req_addr;
        end
        acc_since++;
        model_inflight++;
      end
      if (model_run && redirect_valid) begin
        exp_q.delete();
        model_pc        = redirect_pc;
        pops_since      = 0;
        acc_since       = 0;
        first_pop_seen  = 1'b0;
        first_addr_seen = 1'b0;
      end
      if (mem_resp_valid) begin
        model_inflight--;
        if (!model_run) begin
          vec_cnt++;
          if (vec_cnt == 2) begin
            model_run = 1'b1;
            model_pc  = {vec_hi, vec_lo};
          end
        end
      end
    end
  end

  vec_t tbl[4];

  initial begin
    int unsigned p0, p1;
    bit found;

    tbl[0] = '{16'h4000, 1, 1'b0, 12, 8'h00};
    tbl[1] = '{16'h50F0, 2, 1'b1, 20, 8'hF0};
    tbl[2] = '{16'h6080, 4, 1'b0, 10, 8'h80};
    tbl[3] = '{16'h70FD, 1, 1'b1,  8, 8'hFD};

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    vec_lo         = 8'h34;
    vec_hi         = 8'h12;
    lat            = 2;
    repeat (3) tick();
    @(negedge clk);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_fetch_pc", fetch_pc, 16'h0000);
    tick();
    rst = 1'b0;

    // Reset vector at latency 2
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (first_run_seen) begin
        found = 1'b1;
        break;
      end
    end
    #1;
    check("vec_run_reached", found, 1'b1);
    check("vec_first_run_addr", first_run_addr, 16'h1234);
    wait_pops(4, "vec_pops");
    check("vec_first_byte", first_byte, 8'h34);

    // Streaming from $8000 at latency 1: no bubbles once filled
    rst    = 1'b1;
    vec_lo = 8'h00;
    vec_hi = 8'h80;
    lat    = 1;
    repeat (2) tick();
    rst = 1'b0;
    wait_pops(6, "stream_fill");
    check("stream_first_byte", first_byte, 8'h00);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("stream_no_bubble", instr_valid, 1'b1);
    end
    tick();

    // Table of redirect targets / latencies / ready patterns
    for (int i = 0; i < 4; i++) begin
      lat       = tbl[i].lat;
      rnd_ready = tbl[i].rnd;
      do_redirect(tbl[i].pc);
      wait_pops(tbl[i].nbytes, "tbl_pops");
      check("tbl_first_byte", first_byte, tbl[i].exp_first);
    end
    rnd_ready = 1'b0;
    tick();

    // Backpressure at latency 3
    instr_ready = 1'b0;
    lat         = 3;
    do_redirect(16'h9000);
    repeat (20) tick();
    check("bp_accepts", acc_since, 4);
    @(negedge clk);
    check("bp_req_valid", mem_req_valid, 1'b0);
    check("bp_instr_valid", instr_valid, 1'b1);
    check("bp_head", instr, 8'h00);
    tick();
    instr_ready = 1'b1;
    wait_pops(12, "bp_drain");

    // Redirect with three requests in flight
    do_redirect(16'hA000);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (model_inflight == 3) begin
        found = 1'b1;
        break;
      end
    end
    #1;
    check("inflight3_reached", found, 1'b1);
    do_redirect(16'hC000);
    @(negedge clk);
    check("redir_flushed", instr_valid, 1'b0);
    wait_pops(6, "redir_pops");
    check("redir_first_byte", first_byte, 8'h00);

    // Back-to-back redirects two cycles apart
    lat = 2;
    do_redirect(16'h2000);
    p0 = pops_total;
    tick();
    p1 = pops_total;
    do_redirect(16'h3000);
    check("b2b_no_pop_between", p1, p0);
    wait_pops(6, "b2b_pops");
    check("b2b_first_byte", first_byte, 8'h00);

    // Address wrap, then reset mid-stream
    instr_ready = 1'b0;
    lat         = 1;
    do_redirect(16'hFFFE);
    repeat (12) tick();
    check("wrap_addr0", acc_log[0], 16'hFFFE);
    check("wrap_addr1", acc_log[1], 16'hFFFF);
    check("wrap_addr2", acc_log[2], 16'h0000);
    check("wrap_accepts", acc_since, 4);
    @(negedge clk);
    check("wrap_full_valid", instr_valid, 1'b1);
    vec_lo = 8'h34;
    vec_hi = 8'h12;
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_instr_valid", instr_valid, 1'b0);
    check("midrst_req_valid", mem_req_valid, 1'b0);
    check("midrst_fetch_pc", fetch_pc, 16'h0000);
    tick();
    rst         = 1'b0;
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (first_addr_seen) begin
        found = 1'b1;
        break;
      end
    end
    #1;
    check("midrst_req_seen", found, 1'b1);
    check("midrst_first_addr", first_addr, 16'hFFFC);
    wait_pops(4, "midrst_pops");
    check("midrst_first_byte", first_byte, 8'h34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
